// File: rtl/qpsk_byte_packer.sv
// qpsk_byte_packer: drops guard/pilot bins, packs data dibits MSB-first into bytes and queues them
module qpsk_byte_packer #(
    parameter int N_SC       = 64,
    parameter int DATA_LO    = 4,
    parameter int DATA_HI    = 59,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_en,
    input  logic [1:0] sym,
    input  logic       frame_start,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_last,
    output logic       frame_done,
    output logic       sync_err,
    output logic       overflow
);
    localparam int BW = $clog2(N_SC);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BIN_LO  = BW'(DATA_LO);
    localparam logic [BW-1:0] BIN_HI  = BW'(DATA_HI);
    localparam logic [BW-1:0] BIN_END = BW'(N_SC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bin_q, bin_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [5:0]    shift_q, shift_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   occ_q, occ_d;
    logic          frame_done_q, frame_done_d;
    logic          sync_err_q, sync_err_d;
    logic          overflow_q, overflow_d;

    logic          proc, is_data, push, pop, full, wr_en;
    logic [BW-1:0] bin_cur;
    logic [1:0]    cnt_base;
    logic [5:0]    shift_base;
    logic [7:0]    pk_byte;

    // symbol side: bin tracking, frame FSM and dibit packing (frame_start restarts packing from empty)
    always_comb begin
        proc         = sym_en && (state_q == RUN || frame_start);
        bin_cur      = frame_start ? '0 : bin_q + 1'b1;
        cnt_base     = frame_start ? 2'd0 : cnt_q;
        shift_base   = frame_start ? 6'd0 : shift_q;
        is_data      = proc && bin_cur >= BIN_LO && bin_cur <= BIN_HI;
        push         = is_data && (cnt_base == 2'd3 || bin_cur == BIN_HI);
        pk_byte      = {shift_base, sym} << {2'd3 - cnt_base, 1'b0};
        state_d      = state_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        if (proc) begin
            state_d = bin_cur == BIN_END ? IDLE : RUN;
            bin_d   = bin_cur;
            cnt_d   = push ? 2'd0 : is_data ? cnt_base + 2'd1 : cnt_base;
            shift_d = push ? 6'd0 : is_data ? {shift_base[3:0], sym} : shift_base;
        end
        frame_done_d = proc && bin_cur == BIN_END;
        sync_err_d   = sym_en && frame_start && state_q == RUN;
    end

    // output queue: a pop frees the slot the same cycle, so only push-without-pop when full drops
    always_comb begin
        full       = occ_q == (PW+1)'(FIFO_DEPTH);
        pop        = occ_q != '0 && byte_ready;
        wr_en      = push && (!full || pop);
        mem_d      = mem_q;
        if (wr_en) mem_d[wr_q] = {bin_cur == BIN_HI, pk_byte};
        wr_d       = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        occ_d      = occ_q + (PW+1)'(wr_en) - (PW+1)'(pop);
        overflow_d = overflow_q || (push && full && !pop);
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            mem_q        <= '{default: '0};
            wr_q         <= '0;
            rd_q         <= '0;
            occ_q        <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            occ_q        <= occ_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign byte_valid             = occ_q != '0;
    assign {byte_last, byte_data} = mem_q[rd_q];
    assign frame_done             = frame_done_q;
    assign sync_err               = sync_err_q;
    assign overflow               = overflow_q;
endmodule

// File: tb/tb_qpsk_byte_packer.sv
// tb_qpsk_byte_packer: directed scenarios for the QPSK byte packer
module tb_qpsk_byte_packer;
    logic       clk = 0, reset = 1;
    logic       sym_en = 0, frame_start = 0, byte_ready = 0;
    logic [1:0] sym = 0;
    logic       byte_valid, byte_last, frame_done, sync_err, overflow;
    logic [7:0] byte_data;
    logic       p_sym_en = 0, p_frame_start = 0, p_ready = 1;
    logic [1:0] p_sym = 0;
    logic       p_valid, p_last, p_done, p_err, p_ovf;
    logic [7:0] p_data;
    int checks = 0, passed = 0, cyc = 0;
    int first_valid = -1, fd_n = 0, fd_cyc = 0, se_n = 0, se_cyc = 0;
    logic [8:0] got[$];
    logic [8:0] pgot[$];

    qpsk_byte_packer dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .sym(sym), .frame_start(frame_start),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .byte_last(byte_last), .frame_done(frame_done), .sync_err(sync_err), .overflow(overflow)
    );

    qpsk_byte_packer #(.DATA_HI(9)) dut_p (
        .clk(clk), .reset(reset), .sym_en(p_sym_en), .sym(p_sym), .frame_start(p_frame_start),
        .byte_valid(p_valid), .byte_ready(p_ready), .byte_data(p_data),
        .byte_last(p_last), .frame_done(p_done), .sync_err(p_err), .overflow(p_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // collect accepted bytes and pulses mid-cycle, where inputs and outputs are settled
    always @(negedge clk) begin
        if (byte_valid && byte_ready) got.push_back({byte_last, byte_data});
        if (p_valid && p_ready) pgot.push_back({p_last, p_data});
        if (byte_valid && first_valid < 0) first_valid = cyc;
        if (frame_done) begin fd_n++; fd_cyc = cyc; end
        if (sync_err) begin se_n++; se_cyc = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sym_en = 0;
        frame_start = 0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        sym_en = 0;
        frame_start = 0;
        reset = 0;
        #3;
        reset = 1;
        tick();
    endtask

    // mode 0: data dibits 00,01,10,11; mode 1: guards 11, data 00; mode 2: byte j dibit i = (i+j+1)%4
    function automatic logic [1:0] sym_for(input int mode, input int b);
        int k;
        k = b - 4;
        if (b < 4 || b > 59) return mode == 1 ? 2'd3 : 2'd2;
        return mode == 0 ? 2'(k % 4) : mode == 1 ? 2'd0 : 2'((k + k / 4 + 1) % 4);
    endfunction

    function automatic logic [8:0] exp_byte(input int mode, input int j);
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 4; i++) v = {v[5:0], sym_for(mode, 4 + 4 * j + i)};
        return {j == 13, v};
    endfunction

    task automatic send_bin(input int mode, input int b, input bit fs);
        sym_en = 1;
        frame_start = fs;
        sym = sym_for(mode, b);
        tick();
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #12;
        checks++;
        if ({byte_valid, byte_last, byte_data, frame_done, sync_err, overflow} !== 13'd0)
            $display("FAIL reset_outputs got %b want 0", {byte_valid, byte_last, byte_data, frame_done, sync_err, overflow});
        else passed++;
        @(negedge clk) reset = 1;
        tick();
        checks++;
        if ({byte_valid, frame_done, sync_err, overflow} !== 4'd0)
            $display("FAIL post_reset_outputs got %b want 0", {byte_valid, frame_done, sync_err, overflow});
        else passed++;
    endtask

    task automatic test_nominal();
        int c7, c63;
        logic [8:0] v;
        byte_ready = 1; got.delete(); first_valid = -1; fd_n = 0; se_n = 0;
        for (int b = 0; b < 64; b++) begin
            send_bin(0, b, b == 0);
            if (b == 7) c7 = cyc;
            if (b == 63) c63 = cyc;
        end
        idle(6);
        checks++;
        if (first_valid !== c7) $display("FAIL nominal_first_valid cycle %0d want %0d", first_valid, c7); else passed++;
        checks++;
        if (fd_n !== 1 || fd_cyc !== c63) $display("FAIL nominal_frame_done count %0d cycle %0d want 1 at %0d", fd_n, fd_cyc, c63); else passed++;
        checks++;
        if (se_n !== 0) $display("FAIL nominal_sync_err count %0d want 0", se_n); else passed++;
        checks++;
        if (got.size() !== 14) $display("FAIL nominal_count got %0d want 14", got.size()); else passed++;
        for (int j = 0; j < 14; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            checks++;
            if (v !== {j == 13, 8'h1B}) $display("FAIL nominal_byte%0d got %h want %h", j, v, {j == 13, 8'h1B}); else passed++;
        end
    endtask

    task automatic test_guard_idle();
        logic [8:0] v;
        byte_ready = 1; got.delete();
        for (int i = 0; i < 10; i++) begin
            sym_en = 1; frame_start = 0; sym = 2'd3;
            tick();
        end
        idle(3);
        checks++;
        if (got.size() !== 0 || byte_valid !== 0) $display("FAIL idle_ignore got %0d bytes valid %b want 0", got.size(), byte_valid); else passed++;
        for (int b = 0; b < 64; b++) send_bin(1, b, b == 0);
        idle(6);
        checks++;
        if (got.size() !== 14) $display("FAIL guard_count got %0d want 14", got.size()); else passed++;
        for (int j = 0; j < 14; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            checks++;
            if (v !== {j == 13, 8'h00}) $display("FAIL guard_byte%0d got %h want %h", j, v, {j == 13, 8'h00}); else passed++;
        end
    endtask

    task automatic test_partial();
        logic [8:0] v0, v1;
        pgot.delete(); p_ready = 1;
        for (int b = 0; b < 64; b++) begin
            p_sym_en = 1;
            p_frame_start = b == 0;
            p_sym = (b >= 4 && b <= 7) ? 2'd3 : b == 8 ? 2'd2 : b == 9 ? 2'd1 : 2'd0;
            tick();
        end
        p_sym_en = 0; p_frame_start = 0;
        repeat (4) tick();
        v0 = pgot.size() > 0 ? pgot[0] : 9'bx;
        v1 = pgot.size() > 1 ? pgot[1] : 9'bx;
        checks++;
        if (pgot.size() !== 2) $display("FAIL partial_count got %0d want 2", pgot.size()); else passed++;
        checks++;
        if (v0 !== 9'h0FF) $display("FAIL partial_full_byte got %h want 0ff", v0); else passed++;
        checks++;
        if (v1 !== 9'h190) $display("FAIL partial_padded_byte got %h want 190", v1); else passed++;
    endtask

    task automatic test_backpressure();
        bit bad;
        logic [8:0] v;
        bad = 0; byte_ready = 0; got.delete();
        for (int b = 0; b < 64; b++) begin
            send_bin(2, b, b == 0);
            if (b == 19) begin
                checks++;
                if (overflow !== 0) $display("FAIL bp_overflow_at_4 got %b want 0", overflow); else passed++;
            end
            if (b == 23) begin
                checks++;
                if (overflow !== 1) $display("FAIL bp_overflow_at_5 got %b want 1", overflow); else passed++;
            end
            if (b >= 8 && (byte_valid !== 1 || {byte_last, byte_data} !== exp_byte(2, 0))) bad = 1;
        end
        idle(3);
        checks++;
        if (bad || got.size() !== 0) $display("FAIL bp_hold unstable %0d accepted %0d want 0 0", bad, got.size()); else passed++;
        byte_ready = 1;
        idle(8);
        checks++;
        if (got.size() !== 4) $display("FAIL bp_drain_count got %0d want 4", got.size()); else passed++;
        for (int j = 0; j < 4; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            checks++;
            if (v !== exp_byte(2, j)) $display("FAIL bp_byte%0d got %h want %h", j, v, exp_byte(2, j)); else passed++;
        end
        checks++;
        if (overflow !== 1 || byte_valid !== 0) $display("FAIL bp_sticky overflow %b valid %b want 1 0", overflow, byte_valid); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [8:0] v;
        do_reset();
        byte_ready = 0; got.delete();
        for (int b = 0; b < 23; b++) send_bin(2, b, b == 0);
        byte_ready = 1;
        send_bin(2, 23, 0);
        byte_ready = 0;
        idle(2);
        checks++;
        if (overflow !== 0 || got.size() !== 1) $display("FAIL fpp_no_drop overflow %b popped %0d want 0 1", overflow, got.size()); else passed++;
        byte_ready = 1;
        idle(8);
        checks++;
        if (got.size() !== 5) $display("FAIL fpp_count got %0d want 5", got.size()); else passed++;
        for (int j = 0; j < 5; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            checks++;
            if (v !== exp_byte(2, j)) $display("FAIL fpp_byte%0d got %h want %h", j, v, exp_byte(2, j)); else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] v;
        do_reset();
        got.delete();
        for (int b = 0; b <= 30; b++) begin
            byte_ready = b < 23;
            send_bin(2, b, b == 0);
        end
        sym_en = 0; frame_start = 0;
        checks++;
        if (byte_valid !== 1) $display("FAIL rst_queued valid %b want 1", byte_valid); else passed++;
        #2 reset = 0;
        #1;
        checks++;
        if ({byte_valid, overflow} !== 2'b00) $display("FAIL rst_async valid/overflow %b want 00", {byte_valid, overflow}); else passed++;
        #10;
        got.delete();
        reset = 1;
        byte_ready = 1;
        tick();
        for (int b = 0; b < 64; b++) send_bin(2, b, b == 0);
        idle(8);
        checks++;
        if (got.size() !== 14) $display("FAIL rst_frame_count got %0d want 14", got.size()); else passed++;
        for (int j = 0; j < 14; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            checks++;
            if (v !== exp_byte(2, j)) $display("FAIL rst_byte%0d got %h want %h", j, v, exp_byte(2, j)); else passed++;
        end
    endtask

    task automatic test_resync();
        int cs;
        logic [8:0] v, w;
        byte_ready = 1; got.delete(); se_n = 0; fd_n = 0;
        for (int b = 0; b <= 20; b++) send_bin(2, b, b == 0);
        for (int b = 0; b < 64; b++) begin
            send_bin(2, b, b == 0);
            if (b == 0) cs = cyc;
        end
        idle(8);
        checks++;
        if (se_n !== 1 || se_cyc !== cs) $display("FAIL resync_sync_err count %0d cycle %0d want 1 at %0d", se_n, se_cyc, cs); else passed++;
        checks++;
        if (fd_n !== 1) $display("FAIL resync_frame_done count %0d want 1", fd_n); else passed++;
        checks++;
        if (got.size() !== 18) $display("FAIL resync_count got %0d want 18", got.size()); else passed++;
        for (int j = 0; j < 18; j++) begin
            v = j < got.size() ? got[j] : 9'bx;
            w = j < 4 ? exp_byte(2, j) : exp_byte(2, j - 4);
            checks++;
            if (v !== w) $display("FAIL resync_byte%0d got %h want %h", j, v, w); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_guard_idle();
        test_partial();
        test_backpressure();
        test_full_push_pop();
        test_reset_midframe();
        test_resync();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
